// File: rtl/flood_menu_ctrl.sv
// Flood-It menu / selection controller.
// Edits board size and colour count in SETUP, sequences the rand/game-logic
// init and begin handshakes, turns switch toggles into colour moves in PLAY
// and keeps the try budget.
module flood_menu_ctrl #(
  parameter int NSW        = 8,
  parameter int SIZE_MIN   = 2,
  parameter int SIZE_MAX   = 26,
  parameter int SIZE_STEP  = 4,
  parameter int SIZE_RST   = 14,
  parameter int COL_MIN    = 3,
  parameter int COL_MAX    = NSW,
  parameter int COL_RST    = 6,
  parameter int BUD_NUM    = 23,
  parameter int BUD_SHIFT  = 6,
  parameter int RPT_DELAY  = 50_000_000,
  parameter int RPT_PERIOD = 12_500_000
) (
  input  logic                   MASTER_CLOCK,
  input  logic                   RESET_N,
  input  logic                   UP,
  input  logic                   DOWN,
  input  logic                   LEFT,
  input  logic                   RIGHT,
  input  logic                   CENTER,
  input  logic [NSW-1:0]         sw,
  output logic                   INITIALIZE_BOARD,
  input  logic                   BOARD_READY,
  input  logic                   INITIALIZED,
  output logic                   BEGIN_GAME,
  input  logic                   ACK_BEGIN_GAME,
  output logic                   COLOR_SEL_SIG,
  input  logic                   CURRENTLY_CHANGING_COLOR,
  output logic [$clog2(NSW)-1:0] COLOR_SELECTED,
  output logic [4:0]             SIZE,
  output logic [3:0]             COLOR_NUM,
  output logic [4:0]             final_SIZE,
  output logic [3:0]             final_COLOR_NUM,
  output logic                   sORc,
  output logic                   MODE,
  output logic [7:0]             TRIES,
  output logic [7:0]             TOTAL_TRIES,
  output logic                   OUT_OF_TRIES
);

  localparam int SEL_W = $clog2(NSW);
  // Repeat counter only ever counts up to RPT_DELAY-1; RPT_PERIOD <= RPT_DELAY,
  // RPT_DELAY >= 2 so the first repeat never lands on the press cycle.
  localparam int CW    = $clog2(RPT_DELAY + 1);

  // Button vector order: {CENTER, RIGHT, LEFT, DOWN, UP}
  localparam int B_UP = 0, B_DN = 1, B_LF = 2, B_RT = 3, B_CT = 4;

  typedef enum logic [2:0] {S_BOOT, S_INIT, S_BEGIN, S_PLAY, S_SETUP} state_t;

  state_t          state;
  logic [4:0]      btn, btn_q, rise;
  logic [NSW-1:0]  sw_q, tog;
  logic            init_q, init_fall;
  logic [CW-1:0]   rpt_cnt;
  logic            hold, rpt_fire;
  logic            up_ev, dn_ev, step_up, step_dn;
  logic            hit, accept;
  logic [SEL_W-1:0] idx;

  // budget(s,c) = clamp((s*(c-1)*BUD_NUM) >> BUD_SHIFT, 1, 255), 16-bit math
  function automatic logic [7:0] budget(input logic [4:0] s, input logic [3:0] c);
    logic [15:0] p;
    p = 16'(s) * 16'(4'(c - 4'd1)) * 16'(BUD_NUM);
    p = p >> BUD_SHIFT;
    if (p > 16'd255)     return 8'd255;
    else if (p == 16'd0) return 8'd1;
    else                 return p[7:0];
  endfunction

  // Size step with wrap; anything outside the legal range snaps to reset size
  function automatic logic [4:0] size_step(input logic [4:0] s, input logic up);
    int v;
    v = int'(s);
    if (v < SIZE_MIN || v > SIZE_MAX) return 5'(SIZE_RST);
    if (up) return (v + SIZE_STEP > SIZE_MAX) ? 5'(SIZE_MIN) : 5'(v + SIZE_STEP);
    return (v - SIZE_STEP < SIZE_MIN) ? 5'(SIZE_MAX) : 5'(v - SIZE_STEP);
  endfunction

  // Colour-count step with wrap; out-of-range snaps to reset count
  function automatic logic [3:0] col_step(input logic [3:0] c, input logic up);
    int v;
    v = int'(c);
    if (v < COL_MIN || v > COL_MAX) return 4'(COL_RST);
    if (up) return (v >= COL_MAX) ? 4'(COL_MIN) : 4'(v + 1);
    return (v <= COL_MIN) ? 4'(COL_MAX) : 4'(v - 1);
  endfunction

  assign btn       = {CENTER, RIGHT, LEFT, DOWN, UP};
  assign rise      = btn & ~btn_q;
  assign init_fall = init_q & ~INITIALIZED;
  assign tog       = sw ^ sw_q;

  assign OUT_OF_TRIES = (TRIES >= TOTAL_TRIES);

  // Auto-repeat only while exactly one of UP/DOWN is held in SETUP
  assign hold     = (state == S_SETUP) && (UP ^ DOWN);
  assign rpt_fire = hold && (rpt_cnt == CW'(RPT_DELAY - 1));
  assign up_ev    = rise[B_UP] | (rpt_fire & UP);
  assign dn_ev    = rise[B_DN] | (rpt_fire & DOWN);
  assign step_up  = up_ev & ~DOWN;
  assign step_dn  = dn_ev & ~UP;

  // Lowest toggled switch index wins
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NSW - 1; i >= 0; i--) begin
      if (tog[i]) begin
        hit = 1'b1;
        idx = SEL_W'(i);
      end
    end
  end

  assign accept = (state == S_PLAY) && !COLOR_SEL_SIG && hit && !OUT_OF_TRIES &&
                  (32'(idx) < 32'(final_COLOR_NUM));

  // Input history; the one-cycle BOOT state primes these so a level held
  // through reset never looks like an edge or a toggle.
  always_ff @(posedge MASTER_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      btn_q  <= '0;
      sw_q   <= '0;
      init_q <= 1'b0;
    end else begin
      btn_q  <= btn;
      sw_q   <= sw;
      init_q <= INITIALIZED;
    end
  end

  // Held-button repeat timer; reloads so later repeats come every RPT_PERIOD
  always_ff @(posedge MASTER_CLOCK or negedge RESET_N) begin
    if (!RESET_N)      rpt_cnt <= '0;
    else if (!hold)    rpt_cnt <= '0;
    else if (rpt_fire) rpt_cnt <= CW'(RPT_DELAY - RPT_PERIOD);
    else               rpt_cnt <= rpt_cnt + CW'(1);
  end

  // Menu FSM with registered handshake / edit outputs
  always_ff @(posedge MASTER_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state            <= S_BOOT;
      MODE             <= 1'b1;
      SIZE             <= 5'(SIZE_RST);
      final_SIZE       <= 5'(SIZE_RST);
      COLOR_NUM        <= 4'(COL_RST);
      final_COLOR_NUM  <= 4'(COL_RST);
      sORc             <= 1'b0;
      TRIES            <= 8'd0;
      TOTAL_TRIES      <= budget(5'(SIZE_RST), 4'(COL_RST));
      INITIALIZE_BOARD <= 1'b0;
      BEGIN_GAME       <= 1'b0;
      COLOR_SEL_SIG    <= 1'b0;
      COLOR_SELECTED   <= '0;
    end else begin
      if (COLOR_SEL_SIG && CURRENTLY_CHANGING_COLOR) COLOR_SEL_SIG <= 1'b0;
      case (state)
        S_BOOT: begin
          MODE <= 1'b1;
          if (!INITIALIZED) begin
            state            <= S_INIT;
            INITIALIZE_BOARD <= 1'b1;
            TRIES            <= 8'd0;
          end else begin
            state <= S_PLAY;
          end
        end
        S_INIT: begin
          TRIES <= 8'd0;
          if (BOARD_READY) begin
            INITIALIZE_BOARD <= 1'b0;
            BEGIN_GAME       <= 1'b1;
            state            <= S_BEGIN;
          end
        end
        S_BEGIN: begin
          MODE <= 1'b1;
          if (ACK_BEGIN_GAME) begin
            BEGIN_GAME <= 1'b0;
            state      <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (init_fall) begin
            state            <= S_INIT;
            INITIALIZE_BOARD <= 1'b1;
            MODE             <= 1'b1;
            TRIES            <= 8'd0;
          end else begin
            if (rise[B_RT] && INITIALIZED) begin
              state <= S_SETUP;
              MODE  <= 1'b0;
            end
            if (accept) begin
              COLOR_SELECTED <= idx;
              COLOR_SEL_SIG  <= 1'b1;
              if (TRIES != 8'd255) TRIES <= TRIES + 8'd1;
            end
          end
        end
        S_SETUP: begin
          if (init_fall) begin
            state            <= S_INIT;
            INITIALIZE_BOARD <= 1'b1;
            MODE             <= 1'b1;
            TRIES            <= 8'd0;
          end else if (rise[B_CT]) begin
            final_SIZE       <= SIZE;
            final_COLOR_NUM  <= COLOR_NUM;
            TOTAL_TRIES      <= budget(SIZE, COLOR_NUM);
            TRIES            <= 8'd0;
            INITIALIZE_BOARD <= 1'b1;
            MODE             <= 1'b1;
            state            <= S_INIT;
          end else if (rise[B_RT]) begin
            MODE  <= 1'b1;
            state <= S_PLAY;
          end else begin
            if (rise[B_LF]) sORc <= ~sORc;
            if (step_up || step_dn) begin
              if (sORc) SIZE      <= size_step(SIZE, step_up);
              else      COLOR_NUM <= col_step(COLOR_NUM, step_up);
            end
          end
        end
        default: state <= S_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_flood_menu_ctrl.sv
// Directed bench for flood_menu_ctrl: table-driven SETUP editing plus
// hand-written sequences for handshakes, switch scan, auto-repeat, budget
// exhaustion and reset.
module tb_flood_menu_ctrl;

  localparam int B_UP = 0, B_DN = 1, B_LF = 2, B_RT = 3, B_CT = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       up, dn, lf, rt, ct;
  logic [7:0] sw;
  logic       init_board, board_ready, initialized, begin_game, ack_begin;
  logic       sel_sig, changing;
  logic [2:0] sel;
  logic [4:0] size, fsize;
  logic [3:0] coln, fcoln;
  logic       sorc, mode, oot;
  logic [7:0] tries, total;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  flood_menu_ctrl #(.RPT_DELAY(5), .RPT_PERIOD(3)) dut (
    .MASTER_CLOCK(clk), .RESET_N(rst_n),
    .UP(up), .DOWN(dn), .LEFT(lf), .RIGHT(rt), .CENTER(ct), .sw(sw),
    .INITIALIZE_BOARD(init_board), .BOARD_READY(board_ready), .INITIALIZED(initialized),
    .BEGIN_GAME(begin_game), .ACK_BEGIN_GAME(ack_begin),
    .COLOR_SEL_SIG(sel_sig), .CURRENTLY_CHANGING_COLOR(changing), .COLOR_SELECTED(sel),
    .SIZE(size), .COLOR_NUM(coln), .final_SIZE(fsize), .final_COLOR_NUM(fcoln),
    .sORc(sorc), .MODE(mode), .TRIES(tries), .TOTAL_TRIES(total), .OUT_OF_TRIES(oot)
  );

  typedef struct {
    int btn;
    int size;
    int coln;
    int sorc;
    int mode;
  } vec_t;

  vec_t tbl[13];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      B_UP: up = v;
      B_DN: dn = v;
      B_LF: lf = v;
      B_RT: rt = v;
      default: ct = v;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1);
    tick(1);
    set_btn(b, 1'b0);
    tick(1);
  endtask

  // rand build + game-logic begin handshake, ends in PLAY
  task automatic handshake();
    board_ready = 1'b1; tick(1); board_ready = 1'b0;
    ack_begin   = 1'b1; tick(1); ack_begin   = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " MODE"}, mode, 1);
    chk({tag, " SIZE"}, size, 14);
    chk({tag, " COLOR_NUM"}, coln, 6);
    chk({tag, " final_SIZE"}, fsize, 14);
    chk({tag, " final_COLOR_NUM"}, fcoln, 6);
    chk({tag, " sORc"}, sorc, 0);
    chk({tag, " TRIES"}, tries, 0);
    chk({tag, " TOTAL_TRIES"}, total, 25);
    chk({tag, " INITIALIZE_BOARD"}, init_board, 0);
    chk({tag, " BEGIN_GAME"}, begin_game, 0);
    chk({tag, " COLOR_SEL_SIG"}, sel_sig, 0);
    chk({tag, " OUT_OF_TRIES"}, oot, 0);
  endtask

  initial begin
    // SETUP editing table: {button, SIZE, COLOR_NUM, sORc, MODE} after press
    tbl[0]  = '{B_RT, 14, 6, 0, 0};
    tbl[1]  = '{B_LF, 14, 6, 1, 0};
    tbl[2]  = '{B_UP, 18, 6, 1, 0};
    tbl[3]  = '{B_UP, 22, 6, 1, 0};
    tbl[4]  = '{B_UP, 26, 6, 1, 0};
    tbl[5]  = '{B_UP,  2, 6, 1, 0};
    tbl[6]  = '{B_DN, 26, 6, 1, 0};
    tbl[7]  = '{B_LF, 26, 6, 0, 0};
    tbl[8]  = '{B_DN, 26, 5, 0, 0};
    tbl[9]  = '{B_DN, 26, 4, 0, 0};
    tbl[10] = '{B_DN, 26, 3, 0, 0};
    tbl[11] = '{B_DN, 26, 8, 0, 0};
    tbl[12] = '{B_CT, 26, 8, 0, 1};

    rst_n = 1'b0;
    up = 0; dn = 0; lf = 0; rt = 0; ct = 0; sw = 8'h00;
    board_ready = 0; initialized = 0; ack_begin = 0; changing = 0;
    tick(2);
    chk_reset_vals("reset");

    // Boot with no board: INIT -> BEGIN -> PLAY
    rst_n = 1'b1;
    tick(1);
    chk("boot INITIALIZE_BOARD", init_board, 1);
    board_ready = 1'b1; tick(1); board_ready = 1'b0;
    chk("init INITIALIZE_BOARD drop", init_board, 0);
    chk("init BEGIN_GAME", begin_game, 1);
    initialized = 1'b1;
    ack_begin = 1'b1; tick(1); ack_begin = 1'b0;
    chk("begin BEGIN_GAME drop", begin_game, 0);
    chk("play MODE", mode, 1);
    chk("play TOTAL_TRIES", total, 25);

    // Table-driven SETUP editing and commit
    for (int i = 0; i < 13; i++) begin
      press(tbl[i].btn);
      chk($sformatf("vec%0d SIZE", i), size, tbl[i].size);
      chk($sformatf("vec%0d COLOR_NUM", i), coln, tbl[i].coln);
      chk($sformatf("vec%0d sORc", i), sorc, tbl[i].sorc);
      chk($sformatf("vec%0d MODE", i), mode, tbl[i].mode);
    end
    chk("commit final_SIZE", fsize, 26);
    chk("commit final_COLOR_NUM", fcoln, 8);
    chk("commit TOTAL_TRIES", total, 65);
    chk("commit TRIES", tries, 0);
    chk("commit INITIALIZE_BOARD", init_board, 1);
    handshake();

    // Back to 6 colours: budget(26,6) = 2990>>6 = 46
    press(B_RT); press(B_DN); press(B_DN);
    chk("col6 COLOR_NUM", coln, 6);
    press(B_CT);
    chk("col6 TOTAL_TRIES", total, 46);
    handshake();

    // Switch scan: sw[2] and sw[5] together -> colour 2 only
    sw = 8'h24; tick(1);
    chk("scan COLOR_SEL_SIG", sel_sig, 1);
    chk("scan COLOR_SELECTED", sel, 2);
    chk("scan TRIES", tries, 1);
    sw = 8'h26; tick(1);               // toggle while pending: dropped
    chk("pending SIG held", sel_sig, 1);
    chk("pending TRIES", tries, 1);
    changing = 1'b1; tick(1); changing = 1'b0;
    chk("ack SIG clear", sel_sig, 0);
    tick(2);
    chk("dropped toggles SIG", sel_sig, 0);
    chk("dropped toggles TRIES", tries, 1);
    sw = 8'hA6; tick(1);               // sw[7] >= 6 colours
    chk("range reject SIG", sel_sig, 0);
    chk("range reject TRIES", tries, 1);

    // Auto-repeat: hold UP 5+2*3 cycles -> 4 steps 26->2->6->10->14
    press(B_RT); press(B_LF);
    chk("rpt sORc", sorc, 1);
    up = 1'b1; tick(11); up = 1'b0; tick(1);
    chk("rpt 4 steps", size, 14);
    tick(3);
    chk("rpt release stop", size, 14);
    up = 1'b1; tick(4); up = 1'b0; tick(1);
    chk("rpt cleared short hold", size, 18);
    up = 1'b1; dn = 1'b1; tick(8); up = 1'b0; dn = 1'b0; tick(1);
    chk("both held no change", size, 18);

    // Budget of 1: size 2, 3 colours
    press(B_UP); press(B_UP); press(B_UP);
    press(B_LF); press(B_DN); press(B_DN); press(B_DN);
    chk("bud1 SIZE", size, 2);
    chk("bud1 COLOR_NUM", coln, 3);
    press(B_CT);
    chk("bud1 TOTAL_TRIES", total, 1);
    handshake();
    chk("bud1 OUT_OF_TRIES before", oot, 0);
    sw = 8'hA7; tick(1);
    chk("bud1 move SIG", sel_sig, 1);
    chk("bud1 move COLOR_SELECTED", sel, 0);
    chk("bud1 TRIES", tries, 1);
    chk("bud1 OUT_OF_TRIES", oot, 1);
    changing = 1'b1; tick(1); changing = 1'b0; tick(1);
    sw = 8'hA5; tick(1);
    chk("bud1 second dropped SIG", sel_sig, 0);
    chk("bud1 second dropped TRIES", tries, 1);

    // Reset in the middle of INIT
    press(B_RT); press(B_CT);
    chk("midinit INITIALIZE_BOARD", init_board, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("midinit reset");
    tick(1);
    rst_n = 1'b1;
    tick(1);
    chk("reboot valid board MODE", mode, 1);
    chk("reboot valid board no init", init_board, 0);
    initialized = 1'b0; tick(1);
    chk("board loss INITIALIZE_BOARD", init_board, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
